// File: rtl/result_line_collector.sv
// rtl/result_line_collector.sv - FP16 result FIFO and 256-bit line packer for the result BRAM
// Buffers the compute engine's result stream and writes 16-lane lines per tile.
module result_line_collector #(
  parameter int FIFO_DEPTH   = 64,
  parameter int AFULL_MARGIN = 4,
  parameter int LINE_ADDR_W  = 9
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_tile_en,
  input  logic [LINE_ADDR_W-1:0]      i_wr_base_addr,
  input  logic [15:0]                 i_expected_count,
  input  logic [15:0]                 i_result_data,
  input  logic                        i_result_valid,
  output logic                        o_result_full,
  output logic                        o_result_afull,
  output logic [LINE_ADDR_W-1:0]      o_line_wr_addr,
  output logic                        o_line_wr_en,
  output logic [255:0]                o_line_wr_data,
  input  logic                        i_line_wr_ready,
  output logic                        o_tile_done,
  output logic                        o_overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic [15:0]                 o_line_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(FIFO_DEPTH - AFULL_MARGIN);

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

  state_t                 r_state, w_state_next;
  logic [15:0]            r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_overflow;
  logic [LINE_ADDR_W-1:0] r_addr;
  logic [15:0]            r_expected, r_received, r_line_count;
  logic [3:0]             r_lane_idx;
  logic [255:0]           r_line;
  logic                   r_zero_done;

  logic                   w_full, w_push, w_pop;
  logic                   w_tile_start, w_accept, w_last_accept;
  logic [15:0]            w_head, w_received_inc;

  assign w_full         = (r_count == FULL_LVL);
  assign w_push         = i_result_valid && !w_full;
  assign w_head         = r_fifo_mem[r_rd_ptr];
  assign w_received_inc = r_received + 16'd1;

  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    w_tile_start  = 1'b0;
    w_accept      = 1'b0;
    w_last_accept = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (i_tile_en) begin
          w_tile_start = 1'b1;
          w_state_next = (i_expected_count == 16'd0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (r_lane_idx == 4'd15 || w_received_inc == r_expected)
            w_state_next = WRITE;
        end
      end
      WRITE: begin
        if (i_line_wr_ready) begin
          w_accept = 1'b1;
          if (r_received == r_expected) begin
            w_last_accept = 1'b1;
            w_state_next  = DONE;
          end else begin
            w_state_next  = ACCUM;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  // Storage array carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= i_result_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (i_result_valid && w_full) r_overflow <= 1'b1;
      else if (w_tile_start)        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr       <= '0;
      r_expected   <= '0;
      r_received   <= '0;
      r_line_count <= '0;
      r_lane_idx   <= '0;
      r_line       <= '0;
      r_zero_done  <= 1'b0;
    end else begin
      r_zero_done <= w_tile_start && (i_expected_count == 16'd0);
      if (w_tile_start) begin
        r_addr       <= i_wr_base_addr;
        r_expected   <= i_expected_count;
        r_received   <= '0;
        r_line_count <= '0;
        r_lane_idx   <= '0;
        r_line       <= '0;
      end
      if (w_pop) begin
        r_line[{r_lane_idx, 4'b0000} +: 16] <= w_head;
        r_lane_idx <= r_lane_idx + 4'd1;
        r_received <= w_received_inc;
      end
      // Clearing on acceptance is what zero-pads a final partial line.
      if (w_accept) begin
        r_addr       <= r_addr + LINE_ADDR_W'(1);
        r_line_count <= r_line_count + 16'd1;
        r_line       <= '0;
        r_lane_idx   <= '0;
      end
    end
  end

  assign o_result_full  = w_full;
  assign o_result_afull = (r_count >= AFULL_LVL);
  assign o_fifo_count   = r_count;
  assign o_overflow     = r_overflow;
  assign o_line_wr_en   = (r_state == WRITE);
  assign o_line_wr_addr = r_addr;
  assign o_line_wr_data = r_line;
  assign o_line_count   = r_line_count;
  assign o_tile_done    = w_last_accept || r_zero_done;

endmodule

// File: tb/tb_result_line_collector.sv
// tb/tb_result_line_collector.sv - self-checking bench for result_line_collector
// Table-driven tiles with random data checked against a line-packing model, plus corner sequences.
module tb_result_line_collector;
  logic         i_clk;
  logic         i_reset_n;
  logic         i_tile_en;
  logic [8:0]   i_wr_base_addr;
  logic [15:0]  i_expected_count;
  logic [15:0]  i_result_data;
  logic         i_result_valid;
  logic         o_result_full;
  logic         o_result_afull;
  logic [8:0]   o_line_wr_addr;
  logic         o_line_wr_en;
  logic [255:0] o_line_wr_data;
  logic         i_line_wr_ready;
  logic         o_tile_done;
  logic         o_overflow;
  logic [6:0]   o_fifo_count;
  logic [15:0]  o_line_count;

  result_line_collector #(.FIFO_DEPTH(64), .AFULL_MARGIN(4), .LINE_ADDR_W(9)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_tile_en(i_tile_en),
    .i_wr_base_addr(i_wr_base_addr), .i_expected_count(i_expected_count),
    .i_result_data(i_result_data), .i_result_valid(i_result_valid),
    .o_result_full(o_result_full), .o_result_afull(o_result_afull),
    .o_line_wr_addr(o_line_wr_addr), .o_line_wr_en(o_line_wr_en),
    .o_line_wr_data(o_line_wr_data), .i_line_wr_ready(i_line_wr_ready),
    .o_tile_done(o_tile_done), .o_overflow(o_overflow),
    .o_fifo_count(o_fifo_count), .o_line_count(o_line_count)
  );

  typedef struct {
    logic [8:0]   addr;
    logic [255:0] data;
  } line_t;

  typedef struct {
    logic [8:0] base;
    int         expc;
    int         pattern;
    bit         rrand;
    int         lines;
    logic [8:0] last_addr;
  } vec_t;

  int           checks = 0;
  int           failures = 0;
  int           done_cnt = 0;
  bit           rdy_rand = 0;
  line_t        got_q[$];
  logic [15:0]  data_q[$];
  bit           prev_pend = 0;
  logic [8:0]   prev_addr;
  logic [255:0] prev_data;
  vec_t         tbl[6];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (rdy_rand) i_line_wr_ready = 1'($urandom_range(0, 1));
  endtask

  // Captures accepted writes, counts done pulses, and checks a stalled write stays put.
  always @(negedge i_clk) begin
    line_t e;
    if (!i_reset_n) begin
      prev_pend = 0;
    end else begin
      if (prev_pend && o_line_wr_en) begin
        chk("hold_addr", 256'(o_line_wr_addr), 256'(prev_addr));
        chk("hold_data", o_line_wr_data, prev_data);
      end
      if (o_line_wr_en && i_line_wr_ready) begin
        e.addr = o_line_wr_addr;
        e.data = o_line_wr_data;
        got_q.push_back(e);
      end
      if (o_tile_done) done_cnt++;
      prev_pend = o_line_wr_en && !i_line_wr_ready;
      prev_addr = o_line_wr_addr;
      prev_data = o_line_wr_data;
    end
  end

  // Reference: result i lands in line i/16, lane i%16, at (base + i/16) mod 512; rest zero.
  task automatic compare_lines(input logic [8:0] base, input int expc, input int nlines,
                               input logic [8:0] last_addr);
    logic [255:0] line;
    int nl;
    nl = (expc + 15) / 16;
    chk("line_total", 256'(got_q.size()), 256'(nlines));
    for (int l = 0; l < nl && l < got_q.size(); l++) begin
      line = '0;
      for (int j = 0; j < 16; j++)
        if (l * 16 + j < expc) line[j*16 +: 16] = data_q[l*16 + j];
      chk("line_addr", 256'(got_q[l].addr), 256'((int'(base) + l) % 512));
      chk("line_data", got_q[l].data, line);
    end
    if (got_q.size() > 0) chk("last_addr", 256'(got_q[got_q.size()-1].addr), 256'(last_addr));
    chk("line_count", 256'(o_line_count), 256'(nlines));
  endtask

  task automatic start_tile(input logic [8:0] base, input int expc);
    got_q.delete();
    data_q.delete();
    i_wr_base_addr   = base;
    i_expected_count = 16'(expc);
    i_tile_en        = 1'b1;
    tick();
    i_tile_en        = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin tick(); n++; end
    tick();
    tick();
    chk("tile_done_pulses", 256'(done_cnt - d0), 256'(1));
  endtask

  task automatic run_tile(input vec_t v);
    logic [15:0] val;
    int d0;
    rdy_rand = v.rrand;
    if (!v.rrand) i_line_wr_ready = 1'b1;
    d0 = done_cnt;
    start_tile(v.base, v.expc);
    for (int k = 0; k < v.expc; k++) begin
      while ($urandom_range(0, 3) == 0) tick();
      case (v.pattern)
        0:       val = 16'h3C00 + 16'(k);
        1:       val = 16'(k + 1);
        default: val = 16'($urandom);
      endcase
      i_result_valid = 1'b1;
      i_result_data  = val;
      data_q.push_back(val);
      tick();
      i_result_valid = 1'b0;
    end
    wait_done(d0);
    compare_lines(v.base, v.expc, v.lines, v.last_addr);
    rdy_rand = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_full"},   256'(o_result_full), 256'(0));
    chk({tag, "_afull"},  256'(o_result_afull), 256'(0));
    chk({tag, "_addr"},   256'(o_line_wr_addr), 256'(0));
    chk({tag, "_wr_en"},  256'(o_line_wr_en), 256'(0));
    chk({tag, "_data"},   o_line_wr_data, 256'(0));
    chk({tag, "_done"},   256'(o_tile_done), 256'(0));
    chk({tag, "_ovf"},    256'(o_overflow), 256'(0));
    chk({tag, "_fcount"}, 256'(o_fifo_count), 256'(0));
    chk({tag, "_lcount"}, 256'(o_line_count), 256'(0));
  endtask

  initial begin
    logic [8:0]   saved_addr;
    logic [255:0] saved_data;
    logic [15:0]  val;
    int d0, n;

    tbl[0] = '{9'h010, 16, 0, 1'b0, 1, 9'h010};
    tbl[1] = '{9'h020, 20, 1, 1'b0, 2, 9'h021};
    tbl[2] = '{9'h1FF, 32, 2, 1'b1, 2, 9'h000};
    tbl[3] = '{9'h100,  1, 2, 1'b1, 1, 9'h100};
    tbl[4] = '{9'h055, 47, 2, 1'b1, 3, 9'h057};
    tbl[5] = '{9'h1F0, 33, 2, 1'b1, 3, 9'h1F2};

    i_reset_n = 1'b0; i_tile_en = 1'b0; i_wr_base_addr = '0; i_expected_count = '0;
    i_result_data = '0; i_result_valid = 1'b0; i_line_wr_ready = 1'b0;
    tick(); tick(); tick();
    chk_all_zero("reset");
    i_reset_n = 1'b1;
    tick();

    // First write appears two cycles after the 16th push; done pulses on acceptance.
    i_line_wr_ready = 1'b1;
    d0 = done_cnt;
    start_tile(9'h010, 16);
    for (int k = 0; k < 16; k++) begin
      val = 16'h3C00 + 16'(k);
      i_result_valid = 1'b1; i_result_data = val; data_q.push_back(val);
      tick();
    end
    i_result_valid = 1'b0;
    chk("lat_wr_en_t1", 256'(o_line_wr_en), 256'(0));
    tick();
    chk("lat_wr_en_t2", 256'(o_line_wr_en), 256'(1));
    chk("lat_done", 256'(o_tile_done), 256'(1));
    tick();
    chk("lat_done_fall", 256'(o_tile_done), 256'(0));
    chk("lat_fifo_empty", 256'(o_fifo_count), 256'(0));
    chk("lat_done_pulses", 256'(done_cnt - d0), 256'(1));
    compare_lines(9'h010, 16, 1, 9'h010);

    foreach (tbl[i]) run_tile(tbl[i]);

    // Fill the FIFO while parked in DONE with no write path.
    got_q.delete();
    data_q.delete();
    i_line_wr_ready = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      i_result_valid = 1'b1;
      i_result_data  = 16'(k);
      if (k <= 64) data_q.push_back(16'(k));
      tick();
      if (k == 59) chk("afull_59", 256'(o_result_afull), 256'(0));
      if (k == 60) begin
        chk("afull_60", 256'(o_result_afull), 256'(1));
        chk("full_60", 256'(o_result_full), 256'(0));
      end
      if (k == 63) chk("full_63", 256'(o_result_full), 256'(0));
      if (k == 64) begin
        chk("full_64", 256'(o_result_full), 256'(1));
        chk("ovf_64", 256'(o_overflow), 256'(0));
      end
      if (k == 70) begin
        chk("count_70", 256'(o_fifo_count), 256'(64));
        chk("ovf_70", 256'(o_overflow), 256'(1));
      end
    end
    i_result_valid = 1'b0;
    d0 = done_cnt;
    i_wr_base_addr = 9'h0A0; i_expected_count = 16'd64; i_tile_en = 1'b1;
    tick();
    i_tile_en = 1'b0;
    chk("ovf_cleared", 256'(o_overflow), 256'(0));
    for (int k = 0; k < 20; k++) tick();
    i_line_wr_ready = 1'b1;
    wait_done(d0);
    compare_lines(9'h0A0, 64, 4, 9'h0A3);
    chk("ovf_fifo_empty", 256'(o_fifo_count), 256'(0));

    // Zero-length tile: done one cycle after the start pulse, no writes.
    got_q.delete();
    d0 = done_cnt;
    i_wr_base_addr = 9'h077; i_expected_count = 16'd0; i_tile_en = 1'b1;
    tick();
    i_tile_en = 1'b0;
    chk("zero_done", 256'(o_tile_done), 256'(1));
    tick();
    chk("zero_done_fall", 256'(o_tile_done), 256'(0));
    tick();
    chk("zero_no_writes", 256'(got_q.size()), 256'(0));
    chk("zero_pulses", 256'(done_cnt - d0), 256'(1));

    // A start pulse while a write is stalled must not disturb it.
    i_line_wr_ready = 1'b0;
    d0 = done_cnt;
    start_tile(9'h030, 16);
    for (int k = 0; k < 16; k++) begin
      val = 16'($urandom);
      i_result_valid = 1'b1; i_result_data = val; data_q.push_back(val);
      tick();
    end
    i_result_valid = 1'b0;
    n = 0;
    while (!o_line_wr_en && n < 100) begin tick(); n++; end
    chk("ign_wait_wr_en", 256'(o_line_wr_en), 256'(1));
    saved_addr = o_line_wr_addr;
    saved_data = o_line_wr_data;
    i_wr_base_addr = 9'h155; i_expected_count = 16'd5; i_tile_en = 1'b1;
    tick();
    i_tile_en = 1'b0;
    tick(); tick();
    chk("ign_wr_en", 256'(o_line_wr_en), 256'(1));
    chk("ign_addr", 256'(o_line_wr_addr), 256'(saved_addr));
    chk("ign_data", o_line_wr_data, saved_data);
    i_line_wr_ready = 1'b1;
    wait_done(d0);
    compare_lines(9'h030, 16, 1, 9'h030);

    // Reset with a pending write and 7 results buffered.
    i_line_wr_ready = 1'b0;
    start_tile(9'h040, 32);
    for (int k = 0; k < 23; k++) begin
      i_result_valid = 1'b1; i_result_data = 16'($urandom);
      tick();
    end
    i_result_valid = 1'b0;
    n = 0;
    while (!(o_line_wr_en && o_fifo_count == 7) && n < 100) begin tick(); n++; end
    chk("rst_pre_wr_en", 256'(o_line_wr_en), 256'(1));
    chk("rst_pre_count", 256'(o_fifo_count), 256'(7));
    i_reset_n = 1'b0;
    #2;
    chk_all_zero("midrst");
    tick(); tick();
    i_reset_n = 1'b1;
    tick();
    run_tile(tbl[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
